// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame-buffer pixel writer and reader:
// DRAM command encodings, address field widths and controller states.
package frame_reader_pkg;

  localparam logic [2:0] CMD_READ_ENC  = 3'b001;
  localparam logic [2:0] CMD_WRITE_ENC = 3'b000;

  // Address layout: {pad_hi, base, y, x_group, pad_lo}
  localparam int BASE_W = 6;
  localparam int Y_W    = 10;
  localparam int XG_W   = 7;
  localparam int PAD_W  = 2;
  localparam int ADDR_W = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/frame_reader_buf.sv
// Beat buffer: synchronous FIFO with an extra wrap bit on each pointer so
// full and empty can be told apart. The head entry is presented without a
// read delay so the unpacker can show a pixel as soon as a beat lands.
module frame_reader_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push;
  logic             pop;

  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  // Storage array; not reset, contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/frame_reader.sv
// Frame reader: requests a whole frame from DRAM in 8-pixel groups, buffers
// the returned 128-bit beats and streams them out as 24-bit pixels. A credit
// counter reserves buffer room for every beat before its command is issued.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int         H_ACTIVE  = 800,
  parameter int         V_ACTIVE  = 600,
  parameter int         BUF_DEPTH = 16,
  parameter logic [2:0] CMD_READ  = CMD_READ_ENC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_go,
  input  logic [31:0]   frame_base,
  output logic          busy,
  input  logic          af_full,
  output logic [30:0]   af_addr_din,
  output logic [2:0]    af_cmd_din,
  output logic          af_wr_en,
  input  logic          rdf_valid,
  input  logic [127:0]  rdf_dout,
  output logic          rdf_rd_en,
  output logic [23:0]   pix_dout,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sof,
  output logic          pix_eol
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [Y_W-1:0]  X_END      = Y_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]  X_LAST_GRP = Y_W'(H_ACTIVE - 8);
  localparam logic [Y_W-1:0]  Y_END      = Y_W'(V_ACTIVE - 1);
  localparam logic [CW-1:0]   CRED_FULL  = CW'(BUF_DEPTH);

  state_e              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [Y_W-1:0]      req_x_q, req_x_d;
  logic [Y_W-1:0]      req_y_q, req_y_d;
  logic [Y_W-1:0]      out_x_q, out_x_d;
  logic [Y_W-1:0]      out_y_q, out_y_d;
  logic [CW-1:0]       credits_q, credits_d;

  logic                issue;
  logic                buf_wr;
  logic                buf_full;
  logic                buf_empty;
  logic                pix_fire;
  logic                beat_free;
  logic                last_pix;
  logic [127:0]        head;
  logic [23:0]         lane [4];
  logic                unused_bits;

  frame_reader_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (128)
  ) u_buf (
    .clk       (clk),
    .rst_ni    (rst),
    .wr_en_i   (buf_wr),
    .wr_data_i (rdf_dout),
    .rd_en_i   (beat_free),
    .rd_data_o (head),
    .full_o    (buf_full),
    .empty_o   (buf_empty)
  );

  // Pixel k of a beat lives in the k-th 32-bit word from the top; the upper
  // byte of each word is padding.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = head[127-32*gi-8 -: 24];
  end

  assign unused_bits = ^{head[127:120], head[95:88], head[63:56], head[31:24],
                         frame_base[31:28], frame_base[21:0]};

  assign issue     = (state_q == ST_REQ) && !af_full && (credits_q >= CW'(2));
  assign buf_wr    = (state_q != ST_IDLE) && rdf_valid && !buf_full;
  assign rdf_rd_en = rst && rdf_valid && ((state_q == ST_IDLE) || !buf_full);
  assign pix_valid = !buf_empty;
  assign pix_fire  = pix_valid && pix_ready;
  assign beat_free = pix_fire && (out_x_q[1:0] == 2'd3);
  assign last_pix  = (out_x_q == X_END) && (out_y_q == Y_END);

  assign busy        = (state_q != ST_IDLE);
  assign af_wr_en    = issue;
  assign af_cmd_din  = CMD_READ;
  assign af_addr_din = {{(ADDR_W-BASE_W-Y_W-XG_W-PAD_W){1'b0}}, base_q,
                        req_y_q, req_x_q[Y_W-1:3], {PAD_W{1'b0}}};
  assign pix_dout    = pix_valid ? lane[out_x_q[1:0]] : 24'd0;
  assign pix_sof     = pix_valid && (out_x_q == '0) && (out_y_q == '0);
  assign pix_eol     = pix_valid && (out_x_q == X_END);

  // Next-state: frame start, request walk, output pixel walk and credits.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    req_x_d   = req_x_q;
    req_y_d   = req_y_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    credits_d = credits_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_go) begin
          state_d   = ST_REQ;
          base_d    = frame_base[27:22];
          req_x_d   = '0;
          req_y_d   = '0;
          out_x_d   = '0;
          out_y_d   = '0;
          credits_d = CRED_FULL;
        end
      end
      ST_REQ: begin
        if (issue) begin
          if (req_x_q == X_LAST_GRP) begin
            req_x_d = '0;
            if (req_y_q == Y_END) state_d = ST_DRAIN;
            else                  req_y_d = req_y_q + 1'b1;
          end else begin
            req_x_d = req_x_q + Y_W'(8);
          end
        end
      end
      ST_DRAIN: ;
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) begin
      credits_d = credits_q - (issue ? CW'(2) : CW'(0)) + (beat_free ? CW'(1) : CW'(0));
      if (pix_fire) begin
        if (out_x_q == X_END) begin
          out_x_d = '0;
          out_y_d = out_y_q + 1'b1;
        end else begin
          out_x_d = out_x_q + 1'b1;
        end
        if (last_pix) state_d = ST_IDLE;
      end
    end
  end

  // State, counter and credit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      req_x_q   <= '0;
      req_y_q   <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_x_q   <= req_x_d;
      req_y_q   <= req_y_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      credits_q <= credits_d;
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a 16x8 frame: DRAM model with
// configurable read latency, pixel checker, stall/backpressure and reset cases.
module tb_frame_reader;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int BD = 16;
  localparam int NPIX = H * V;
  localparam int NCMD = NPIX / 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         frame_go = 1'b0;
  logic [31:0]  frame_base = 32'd0;
  logic         busy;
  logic         af_full = 1'b0;
  logic [30:0]  af_addr_din;
  logic [2:0]   af_cmd_din;
  logic         af_wr_en;
  logic         rdf_valid = 1'b0;
  logic [127:0] rdf_dout = '0;
  logic         rdf_rd_en;
  logic [23:0]  pix_dout;
  logic         pix_valid;
  logic         pix_ready = 1'b0;
  logic         pix_sof;
  logic         pix_eol;

  frame_reader #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .BUF_DEPTH (BD),
    .CMD_READ  (3'b001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_go    (frame_go),
    .frame_base  (frame_base),
    .busy        (busy),
    .af_full     (af_full),
    .af_addr_din (af_addr_din),
    .af_cmd_din  (af_cmd_din),
    .af_wr_en    (af_wr_en),
    .rdf_valid   (rdf_valid),
    .rdf_dout    (rdf_dout),
    .rdf_rd_en   (rdf_rd_en),
    .pix_dout    (pix_dout),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DRAM model ----------------
  int           cyc = 0;
  int           lat_lo = 1;
  int           lat_hi = 1;
  int           last_ready = 0;
  logic [127:0] beat_q[$];
  int           ready_q[$];
  logic [30:0]  cmd_q[$];
  int           ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  int           full_mode = 0;    // 0: never full, 1: toggle every cycle

  function automatic logic [31:0] pixw(input int y, input int x);
    return {8'hA5, 24'(y * H + x)};
  endfunction

  always @(posedge clk) begin
    int y;
    int x0;
    int r;
    logic [127:0] beat;
    cyc++;
    if (rdf_rd_en && rdf_valid) begin
      void'(beat_q.pop_front());
      void'(ready_q.pop_front());
    end
    if (af_wr_en) begin
      chk("cmd_when_full", {63'd0, af_full}, 64'd0);
      chk("cmd_code", {61'd0, af_cmd_din}, 64'd1);
      cmd_q.push_back(af_addr_din);
      $display("cmd %0d addr=%08h", cmd_q.size() - 1, af_addr_din);
      y  = int'(af_addr_din[18:9]);
      x0 = int'(af_addr_din[8:2]) * 8;
      for (int b = 0; b < 2; b++) begin
        beat = {pixw(y, x0 + 4*b), pixw(y, x0 + 4*b + 1),
                pixw(y, x0 + 4*b + 2), pixw(y, x0 + 4*b + 3)};
        r = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (r < last_ready) r = last_ready;
        last_ready = r;
        beat_q.push_back(beat);
        ready_q.push_back(r);
      end
    end
    rdf_valid <= (beat_q.size() > 0) && (ready_q[0] <= cyc);
    rdf_dout  <= (beat_q.size() > 0) ? beat_q[0] : '0;
  end

  // Consumer-side and address-FIFO stimulus, changed just after each edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(1, 0));
    endcase
    af_full = (full_mode != 0) ? ~af_full : 1'b0;
  end

  // ---------------- Pixel checker ----------------
  int          exp_idx = 0;
  logic        expect_no_pix = 1'b0;
  logic        stall_prev = 1'b0;
  logic [23:0] prev_dout = '0;

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (expect_no_pix) chk("no_pix_in_idle", {63'd0, pix_valid}, 64'd0);
      if (stall_prev) begin
        chk("stall_valid", {63'd0, pix_valid}, 64'd1);
        chk("stall_data", {40'd0, pix_dout}, {40'd0, prev_dout});
      end
      if (pix_valid && pix_ready && !expect_no_pix) begin
        chk("pix_data", {40'd0, pix_dout}, 64'(exp_idx));
        chk("pix_sof", {63'd0, pix_sof}, {63'd0, exp_idx == 0});
        chk("pix_eol", {63'd0, pix_eol}, {63'd0, (exp_idx % H) == H - 1});
        exp_idx++;
      end
      stall_prev = pix_valid && !pix_ready;
      prev_dout  = pix_dout;
      if (busy) chk("credit_range", {63'd0, 32'(dut.credits_q) <= BD}, 64'd1);
    end
  end

  // ---------------- Sequencing tasks ----------------
  task automatic start_frame(input logic [31:0] base);
    @(posedge clk);
    #1;
    cmd_q.delete();
    exp_idx    = 0;
    frame_base = base;
    frame_go   = 1'b1;
    @(posedge clk);
    #1;
    frame_go = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && busy; i++) @(posedge clk);
    @(negedge clk);
    chk("done_in_time", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_frame(input string name, input logic [5:0] base6);
    logic [30:0] ea;
    chk("n_pix", 64'(exp_idx), 64'(NPIX));
    chk("n_cmds", 64'(cmd_q.size()), 64'(NCMD));
    for (int i = 0; i < cmd_q.size() && i < NCMD; i++) begin
      ea = {6'd0, base6, 10'(i / (H / 8)), 7'(i % (H / 8)), 2'd0};
      chk("cmd_addr", {33'd0, cmd_q[i]}, {33'd0, ea});
    end
    $display("frame %s: %0d cmds, %0d pixels", name, cmd_q.size(), exp_idx);
  endtask

  task automatic run_frame(input string name, input logic [31:0] base, input int limit);
    start_frame(base);
    wait_done(limit);
    check_frame(name, base[27:22]);
  endtask

  initial begin
    // Reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_af_wr_en", {63'd0, af_wr_en}, 64'd0);
    chk("rst_rdf_rd_en", {63'd0, rdf_rd_en}, 64'd0);
    chk("rst_pix_valid", {63'd0, pix_valid}, 64'd0);
    chk("rst_sof_eol", {62'd0, pix_sof, pix_eol}, 64'd0);
    chk("rst_addr", {33'd0, af_addr_din}, 64'd0);
    chk("rst_cmd", {61'd0, af_cmd_din}, 64'd1);
    chk("rst_pix_dout", {40'd0, pix_dout}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic frame, consumer always ready, short latency
    ready_mode = 1;
    run_frame("basic", 32'd0, 2000);

    // Consumer stalled: requests must stop once the buffer is reserved
    ready_mode = 0;
    start_frame(32'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("stall_n_cmds", 64'(cmd_q.size()), 64'(BD / 2));
    chk("stall_wr_en", {63'd0, af_wr_en}, 64'd0);
    chk("stall_head_valid", {63'd0, pix_valid}, 64'd1);
    chk("stall_head_pix", {40'd0, pix_dout}, 64'd0);
    chk("stall_head_sof", {63'd0, pix_sof}, 64'd1);
    ready_mode = 1;
    wait_done(2000);
    check_frame("stall", 6'd0);

    // Address FIFO full every other cycle
    full_mode = 1;
    run_frame("af_full_toggle", 32'd0, 2000);
    full_mode = 0;

    // Non-zero base; a second frame_go while busy must be ignored
    start_frame(32'h0840_0000);
    repeat (3) @(posedge clk);
    #1;
    frame_base = 32'd0;
    frame_go   = 1'b1;
    @(posedge clk);
    #1 frame_go = 1'b0;
    wait_done(2000);
    check_frame("base_0840", 6'b100001);
    for (int i = 0; i < cmd_q.size(); i++)
      chk("base_field", {58'd0, cmd_q[i][24:19]}, {58'd0, 6'b100001});

    // Reset mid-request with beats still in flight
    lat_lo = 10;
    lat_hi = 10;
    start_frame(32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_wr_en", {63'd0, af_wr_en}, 64'd0);
    chk("mid_rst_rd_en", {63'd0, rdf_rd_en}, 64'd0);
    chk("mid_rst_valid", {63'd0, pix_valid}, 64'd0);
    chk("mid_rst_addr", {33'd0, af_addr_din}, 64'd0);
    chk("stale_in_flight", {63'd0, beat_q.size() >= 3}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    expect_no_pix = 1'b1;
    for (int i = 0; i < 60 && beat_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stale_drained", 64'(beat_q.size()), 64'd0);
    chk("idle_after_stale", {63'd0, busy}, 64'd0);
    expect_no_pix = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    run_frame("after_reset", 32'd0, 2000);

    // Random consumer and random read latency
    ready_mode = 2;
    lat_lo = 1;
    lat_hi = 20;
    for (int f = 0; f < 3; f++) run_frame("random", 32'h0040_0000 * f, 4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
